simple_proc_n: RTL
==================

Name: simple_proc_n

Overview:
Parametrised successor to the fixed 9-bit multi-cycle processor. It keeps the Run/Done instruction handshake and the T0..T3 step sequencer. It is generalised in data width and register-file depth, and adds four new ALU ops, Z/C status flags, a flag-conditional move, and a debug read port. It is the core execution block fed by the instruction/data source on DataIn.

Parameters:
DATA_W, 9, datapath and instruction width in bits; must satisfy DATA_W >= 3 + 2*RSEL_W.
NREG, 8, number of general registers; power of 2, 2..16; RSEL_W = log2(NREG).

Ports:
clock  in  1  single clock, all state updates on rising edge
aResetn  in  1  synchronous active-low reset, sampled on rising edge of clock
Run  in  1  start request; sampled only in step T0
DataIn  in  DATA_W  instruction word in T0; immediate operand in T1 of mvi
Done  out  1  high (combinational from state) in the final step of each instruction
BusWires  out  DATA_W  current internal bus value; 0 when idle
Zflag  out  1  zero flag
Cflag  out  1  carry flag (sub: carry = NOT borrow)
DbgSel  in  RSEL_W  debug register select
DbgData  out  DATA_W  combinational read of R[DbgSel]

Behaviour:
- Reset (aResetn=0 at a clock edge): step<=T0; IR, A, G, R[0..NREG-1], Zflag and Cflag all <=0. Outputs after reset: Done=0, BusWires=0. Reset overrides any in-flight instruction, and a partial result is never written.
- IR format: opcode = IR[DATA_W-1 -: 3]; Rx = the next RSEL_W bits; Ry = the next RSEL_W bits; remaining low bits are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mvnz.
- T0: if Run=1, IR<=DataIn and step<=T1. Otherwise stay in T0; nothing changes and Done=0.
- mv (T1): BusWires=R[Ry]; R[Rx]<=R[Ry]; Done=1; step<=T0. Latency 2 cycles.
- mvi (T1): BusWires=DataIn; R[Rx]<=DataIn; Done=1; step<=T0.
- mvnz (T1): if Zflag=0, R[Rx]<=R[Ry]; if Zflag=1, no write. Done=1 in either case; step<=T0.
- ALU ops, 4 cycles total:
  - T1: A<=R[Rx]; BusWires=R[Rx].
  - T2: G<=A op R[Ry]; BusWires=R[Ry]; Zflag<=(result==0). Cflag is updated only by add/sub; and/or/xor leave Cflag unchanged.
  - T3: R[Rx]<=G; BusWires=G; Done=1; step<=T0.
- Arithmetic: DATA_W-bit wrap-around.
  - add: C = carry out of bit DATA_W-1.
  - sub: computed as A + ~B + 1, with C = that carry out, so Rx==Ry gives result 0, Z=1, C=1.
- Flags are written only in T2 of ALU ops. mv, mvi and mvnz never change them.
- Rx==Ry is legal for every op: it reads the old value and writes the new value at the end.
- Run is ignored outside T0. Run held high causes back-to-back instructions, with T0 immediately following each Done step.
- DbgData reflects register contents the cycle after a write.

Decomposition:
- Package proc_pkg: opcode localparams (OP_MV..OP_MVNZ); tstep_t enum {T0,T1,T2,T3}; alu_op_t enum {ALU_ADD,ALU_SUB,ALU_AND,ALU_OR,ALU_XOR}.
- Sub-module proc_alu: purely combinational, parametrised by DATA_W; inputs a, b, op; outputs result and carry.
- Sequencer, register file and bus mux live in simple_proc_n.

Test Plan:
- Reset, then Run=0 for 5 cycles -> Done=0 throughout, BusWires=0, all registers 0, flags 0.
- Defaults, mvi R0,0x1FF then mv R1,R0 -> Done pulses in cycle 2 of each; DbgSel=1 gives DbgData=0x1FF.
- R0=0x1FF, R2=0x001, add R0,R2 -> Done in cycle 4; R0=0x000, Z=1, C=1.
- sub R3,R3 with R3=0x05A -> R3=0x000, Z=1, C=1; then mvnz R4,R1 -> R4 unchanged, Done=1 in cycle 2.
- DATA_W=16, NREG=4: R1=0x00F0, R2=0x0FF0, xor R1,R2 -> R1=0x0F00, Z=0, C unchanged from the prior add/sub.
- aResetn=0 in T2 of an add -> next cycle step=T0, registers and flags 0, Done never asserted for the aborted instruction.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the simple_proc_n processor: opcodes, step encoding
// and ALU operation selection.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;

  // Map an instruction opcode onto the ALU operation it needs; non-ALU
  // opcodes fall back to add, which is harmless because they never reach T2.
  function automatic alu_op_t alu_op_of(input logic [2:0] opcode);
    alu_op_t op;
    case (opcode)
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub with carry out, bitwise and/or/xor.
// Subtraction is a + ~b + 1 so carry means "no borrow".
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  // Compute the selected operation; carry is only meaningful for add/sub.
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/simple_proc_n.sv
// Multi-cycle processor core: T0..T3 sequencer, NREG x DATA_W register file,
// internal bus mux, Z/C flags and a combinational debug read port.
// DATA_W must be at least 3 + 2*RSEL_W so opcode, Rx and Ry fit in a word.
module simple_proc_n
  import proc_pkg::*;
#(
  parameter int  DATA_W = 9,
  parameter int  NREG   = 8,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              aResetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic              Zflag,
  output logic              Cflag,
  input  logic [RSEL_W-1:0] DbgSel,
  output logic [DATA_W-1:0] DbgData
);

  // Only the decoded fields of the instruction are kept; trailing bits are
  // don't-care.
  localparam int IR_W = 3 + 2 * RSEL_W;

  tstep_t            step_q, step_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic [2:0]        opcode;
  logic [RSEL_W-1:0] rx, ry;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign opcode = ir_q[IR_W-1 -: 3];
  assign rx     = ir_q[2*RSEL_W-1 -: RSEL_W];
  assign ry     = ir_q[RSEL_W-1:0];
  assign alu_op = alu_op_of(opcode);

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (regs_q[ry]),
    .op     (alu_op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Step sequencer, bus mux and next-state for every register.
  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    z_d      = z_q;
    c_d      = c_q;
    regs_d   = regs_q;
    Done     = 1'b0;
    BusWires = '0;
    case (step_q)
      T0: begin
        if (Run) begin
          ir_d   = DataIn[DATA_W-1 -: IR_W];
          step_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            BusWires   = regs_q[ry];
            regs_d[rx] = regs_q[ry];
            Done       = 1'b1;
            step_d     = T0;
          end
          OP_MVI: begin
            BusWires   = DataIn;
            regs_d[rx] = DataIn;
            Done       = 1'b1;
            step_d     = T0;
          end
          OP_MVNZ: begin
            BusWires = regs_q[ry];
            if (!z_q) begin
              regs_d[rx] = regs_q[ry];
            end
            Done   = 1'b1;
            step_d = T0;
          end
          default: begin
            BusWires = regs_q[rx];
            a_d      = regs_q[rx];
            step_d   = T2;
          end
        endcase
      end
      T2: begin
        BusWires = regs_q[ry];
        g_d      = alu_result;
        z_d      = (alu_result == '0);
        if (alu_op == ALU_ADD || alu_op == ALU_SUB) begin
          c_d = alu_carry;
        end
        step_d = T3;
      end
      T3: begin
        BusWires   = g_q;
        regs_d[rx] = g_q;
        Done       = 1'b1;
        step_d     = T0;
      end
      default: step_d = T0;
    endcase
  end

  // Sequencer, IR, A, G and flag registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!aResetn) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      z_q    <= z_d;
      c_q    <= c_d;
    end
  end

  // One flop bank per general register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      always_ff @(posedge clock) begin
        if (!aResetn) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  assign Zflag   = z_q;
  assign Cflag   = c_q;
  assign DbgData = regs_q[DbgSel];

endmodule
